// File: rtl/npc_mem_bridge.sv
// npc_mem_bridge: turns the core's combinational MEM-stage data access into a
// registered valid/ready request/response bus transaction. The core is stalled
// through hold_o until the response (or a timeout) completes the access. Read
// data is then presented for one commit cycle.
//
// Handshake semantics: a request transfers on a cycle where req_valid_o and
// req_ready_i are both 1. A response transfers on a cycle where rsp_valid_i and
// rsp_ready_o are both 1. Once req_valid_o is raised, it and all req_* fields
// stay stable until the transfer. The one exception is a timeout abort, which
// drops req_valid_o without a transfer.
module npc_mem_bridge #(
    parameter int DATA_W  = 64,
    parameter int ADDR_W  = 64,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_ce_i,
    input  logic              mem_we_i,
    input  logic [ADDR_W-1:0] mem_raddr_i,
    input  logic [ADDR_W-1:0] mem_waddr_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    output logic [DATA_W-1:0] mem_rdata_o,
    output logic              hold_o,
    output logic              req_valid_o,
    input  logic              req_ready_i,
    output logic              req_we_o,
    output logic [ADDR_W-1:0] req_addr_o,
    output logic [DATA_W-1:0] req_wdata_o,
    input  logic              rsp_valid_i,
    output logic              rsp_ready_o,
    input  logic [DATA_W-1:0] rsp_rdata_i,
    input  logic              rsp_err_i,
    output logic              bus_err_o
);

    // Counter is wide enough to hold TIMEOUT itself. This matters when a
    // request handshake lands on the last allowed cycle.
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RSP  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              stale_q, stale_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              timeout_hit;

    // The current REQ/RSP cycle is the last one allowed.
    assign timeout_hit = (cnt_q >= CNT_LAST);

    // State and datapath registers; reset abandons any in-flight transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            stale_q <= 1'b0;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            stale_q <= stale_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic: capture, request handshake, response or timeout, commit.
    always_comb begin
        state_d = state_q;
        stale_d = stale_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                // A late response to an aborted access is swallowed here.
                if (stale_q && rsp_valid_i) begin
                    stale_d = 1'b0;
                end
                if (mem_ce_i && !stale_q) begin
                    we_d    = mem_we_i;
                    addr_d  = mem_we_i ? mem_waddr_i : mem_raddr_i;
                    wdata_d = mem_wdata_i;
                    cnt_d   = '0;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                cnt_d = cnt_q + CNT_ONE;
                if (req_ready_i) begin
                    state_d = S_RSP;
                end else if (timeout_hit) begin
                    // Bus never accepted the request, so no response is owed.
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_RSP: begin
                cnt_d = cnt_q + CNT_ONE;
                if (rsp_valid_i) begin
                    // A response on the last cycle still wins over the timeout.
                    rdata_d = (we_q || rsp_err_i) ? '0 : rsp_rdata_i;
                    err_d   = rsp_err_i;
                    state_d = S_DONE;
                end else if (timeout_hit) begin
                    // Bus still owes a response; mark it for discard.
                    rdata_d = '0;
                    err_d   = 1'b1;
                    stale_d = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are decoded from registered state only, except hold_o in IDLE.
    // hold_o must freeze the core in the same cycle it raises mem_ce_i.
    assign hold_o      = ((state_q == S_IDLE) && mem_ce_i) ||
                         (state_q == S_REQ) || (state_q == S_RSP);
    assign req_valid_o = (state_q == S_REQ);
    assign req_we_o    = (state_q == S_REQ) ? we_q    : 1'b0;
    assign req_addr_o  = (state_q == S_REQ) ? addr_q  : '0;
    assign req_wdata_o = (state_q == S_REQ) ? wdata_q : '0;
    assign rsp_ready_o = (state_q == S_RSP) || ((state_q == S_IDLE) && stale_q);
    assign mem_rdata_o = (state_q == S_DONE) ? rdata_q : '0;
    assign bus_err_o   = err_q;

endmodule

// File: doc/npc_mem_bridge.md
# npc_mem_bridge

Data-memory bridge sitting directly downstream of the single-cycle core's MEM stage. It takes the core's combinational data-memory request (`mem_ce`/`mem_we`/addresses/write data) and converts it into a registered valid/ready request/response bus transaction. It stalls the core through `hold_o` until the transaction completes, then returns read data for one cycle. It also enforces a response timeout and discards stale responses.

## Interface
- `DATA_W`, 64: data width, matches `MemBus`.
- `ADDR_W`, 64: address width, matches `MemAddrBus`.
- `TIMEOUT`, 255: maximum cycles spent in REQ+RSP before abort; at least 2.

Ports:
- `clk` in 1: single clock, all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `mem_ce_i` in 1: core requests a memory access.
- `mem_we_i` in 1: 1 = write, 0 = read; valid with `mem_ce_i`.
- `mem_raddr_i` in ADDR_W: read address.
- `mem_waddr_i` in ADDR_W: write address.
- `mem_wdata_i` in DATA_W: write data.
- `mem_rdata_o` out DATA_W: read data to core; valid in DONE only, 0 otherwise.
- `hold_o` out 1: stall core; the core must not advance its PC or commit while this is 1.
- `req_valid_o` out 1: bus request valid.
- `req_ready_i` in 1: bus accepts request.
- `req_we_o` out 1: bus write.
- `req_addr_o` out ADDR_W: bus address.
- `req_wdata_o` out DATA_W: bus write data.
- `rsp_valid_i` in 1: bus response valid.
- `rsp_ready_o` out 1: bridge accepts response.
- `rsp_rdata_i` in DATA_W: response data; ignored for writes.
- `rsp_err_i` in 1: response error.
- `bus_err_o` out 1: one-cycle pulse on error response or timeout.

## Operation
- FSM states: IDLE, REQ, RSP, DONE.
- **IDLE**
  - With `mem_ce_i`=1 and `stale`=0: capture `we`, `addr` (`mem_waddr_i` if `mem_we_i`, else `mem_raddr_i`) and `wdata`. Clear the timeout counter and go to REQ.
  - `hold_o` = `mem_ce_i`, combinational, so the core is frozen in the same cycle.
- **REQ**
  - `req_valid_o`=1 with captured fields, held stable until `req_ready_i`.
  - On handshake, go to RSP.
- **RSP**
  - `rsp_ready_o`=1.
  - On `rsp_valid_i`: capture `rsp_rdata_i` (forced to 0 if write or `rsp_err_i`). Pulse `bus_err_o` if `rsp_err_i`. Go to DONE.
- **DONE**
  - `hold_o`=0 and `mem_rdata_o` = captured data. The core commits at this clock edge.
  - Always return to IDLE; `mem_ce_i` is ignored in DONE.
- **Timeout**
  - The counter increments each cycle in REQ or RSP. When it reaches `TIMEOUT`: pulse `bus_err_o`, set captured rdata to 0, go to DONE.
  - If the abort happens in REQ, `req_valid_o` drops. This is the only case where valid drops without a handshake.
  - If the abort happens in RSP, set `stale`.
- **Stale**
  - While `stale`=1: `rsp_ready_o`=1 in IDLE and the next `rsp_valid_i` is consumed and discarded, which clears `stale`.
  - New requests wait in IDLE with `hold_o`=1 until `stale` clears.
- `hold_o` = (IDLE & `mem_ce_i`) | REQ | RSP.
- Writes also wait for a response (write ack) before releasing the core.

## Timing
- Reset values:
  - state IDLE, `stale`=0, counter 0.
  - `hold_o` = `mem_ce_i`, combinational.
  - All other outputs 0.
- Minimum access is 4 cycles: IDLE detect, REQ (ready=1), RSP (rsp_valid=1), DONE. That is 3 stalled cycles plus the commit cycle.
- Each extra cycle of `req_ready_i`=0 or `rsp_valid_i`=0 adds one cycle of latency.
- `req_*` outputs come from registers; no combinational path from `mem_*_i` to `req_*`.
- A `rsp_valid_i` arriving in REQ (before the request handshake) is a protocol violation and is ignored: `rsp_ready_o`=0 in REQ.
- Timeout and `rsp_valid_i` in the same RSP cycle: the response wins and no timeout is raised.
- Reset mid-transaction: immediate return to IDLE, `stale` cleared, in-flight bus transaction abandoned.
- `bus_err_o` is exactly one cycle, asserted in the cycle the FSM enters DONE.

## Test plan
- **Read, zero wait:** `mem_ce_i`=1, `we`=0, `raddr`=0x80000010; bus ready immediately, `rsp_rdata_i`=0xDEADBEEF_00000001 -> `hold_o` high for 3 cycles; `req_addr_o`=0x80000010; in DONE `mem_rdata_o`=0xDEADBEEF_00000001 and `hold_o`=0.
- **Write with backpressure:** `we`=1, `waddr`=0x80001000, `wdata`=0x1234; `req_ready_i` low for 3 cycles -> `req_valid_o` and all fields stable for 4 cycles; `req_we_o`=1; `mem_rdata_o`=0 in DONE; total 7 cycles.
- **Error response:** read with `rsp_err_i`=1 and `rsp_rdata_i`=0xFF -> `bus_err_o` 1-cycle pulse entering DONE; `mem_rdata_o`=0.
- **Timeout in RSP, then stale drain:** `TIMEOUT`=8 and no response -> DONE after 8 REQ+RSP cycles with `bus_err_o` pulse. Next `mem_ce_i` stays held until a late `rsp_valid_i` is discarded; the following request then completes with correct data.
- **Back-to-back accesses:** two consecutive memory instructions -> the second is captured on the cycle after DONE; no request is issued during DONE.
- **Reset mid-REQ:** `rst_n` low while `req_valid_o`=1 -> all outputs 0 immediately; after release, a normal read completes.
